serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial adder sequencer that time-shares one 1-bit full-adder cell across a WIDTH-bit add. It accepts an operand pair plus carry-in through a valid/ready handshake and feeds one bit pair per cycle, LSB first, through the cell. A carry flop closes the loop between cycles. It returns the WIDTH-bit sum and the carry-out through a second valid/ready handshake. It sits between the operand source and the consumer wherever area matters more than adder latency.

## Interface
- WIDTH, 4, operand and sum width in bits; legal range 2..32.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- start_valid  in  1  operand pair offered.
- start_ready  out  1  block can accept operands; high only in IDLE.
- a  in  WIDTH  operand A; sampled on accept.
- b  in  WIDTH  operand B; sampled on accept.
- cin  in  1  carry-in; sampled on accept.
- res_valid  out  1  result available; high only in DONE.
- res_ready  in  1  consumer takes the result.
- sum  out  WIDTH  (a + b + cin) mod 2^WIDTH; valid while res_valid.
- cout  out  1  bit WIDTH of a + b + cin; valid while res_valid.
- busy  out  1  high in RUN or DONE.

## Operation
- States are IDLE, RUN and DONE.
- Accept: start_valid && start_ready at a clk edge. On accept:
  - a_sh <= a, b_sh <= b, carry <= cin.
  - sum_sh is cleared.
  - cnt <= 0.
  - The FSM moves to RUN.
- RUN, every cycle:
  - The cell computes s = a_sh[0] ^ b_sh[0] ^ carry and co = majority(a_sh[0], b_sh[0], carry).
  - a_sh and b_sh shift right one bit.
  - sum_sh shifts right one bit, with s entering at bit WIDTH-1.
  - carry <= co.
  - cnt increments.
- RUN ends on the cycle with cnt == WIDTH-1; the FSM then moves to DONE. After WIDTH RUN cycles, sum_sh holds the full sum with bit 0 at the LSB.
- DONE:
  - res_valid = 1, sum = sum_sh, cout = carry.
  - sum and cout hold stable until res_valid && res_ready, then the FSM moves to IDLE.
- Outside DONE, sum and cout drive the last completed result. They are zero after reset.
- start_valid outside IDLE is ignored; the operand source must hold its offer until accepted.
- res_ready outside DONE has no effect.
- Arithmetic: unsigned. Overflow appears only on cout. There is no sign or saturation logic.
- cnt is $clog2(WIDTH) bits and never wraps within one operation.

## Timing
- Reset values:
  - State IDLE.
  - start_ready = 1.
  - res_valid = 0, busy = 0.
  - sum = 0, cout = 0.
  - All internal registers = 0.
- rst wins over every other input in the same cycle. Reset asserted during RUN or DONE discards the operation; no res_valid is produced for it.
- Latency:
  - Accept edge at cycle 0.
  - RUN occupies cycles 1..WIDTH.
  - res_valid rises in cycle WIDTH+1.
- Minimum issue interval is WIDTH+2 cycles: IDLE, WIDTH RUN cycles, one DONE cycle with res_ready high.
- Backpressure: DONE may last indefinitely. start_ready stays low throughout.
- All outputs are registered or decoded from the state only. There is no combinational path from any input to any output.

## Structure
- Package serial_add_pkg holds:
  - State enum state_e: IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10.
  - Constant MAX_WIDTH = 32.
- Sub-module fa_bit: purely combinational 1-bit full adder with ports a, b, cin, sum, cout. It is instantiated once.
- The top module holds the FSM, the counter, the three shift registers and the carry flop.

## Test plan
- WIDTH=4. Reset for 2 cycles, then release -> start_ready=1, res_valid=0, busy=0, sum=0, cout=0.
- Issue the following adds, with res_valid rising exactly 5 cycles after each accept:
  - a=1, b=1, cin=1 -> sum=3, cout=0.
  - a=4, b=2, cin=0 -> sum=6, cout=0.
  - a=3, b=3, cin=1 -> sum=7, cout=0.
- Carry chain:
  - a=15, b=1, cin=0 -> sum=0, cout=1.
  - a=15, b=15, cin=1 -> sum=15, cout=1.
- Backpressure: a=4, b=4, cin=0 with res_ready low for 6 cycles -> sum=8, cout=0 held stable. start_ready stays 0. A second start_valid offered meanwhile is not accepted until the cycle after the result handshake.
- Reset mid-RUN: accept a=2, b=4, cin=1, then assert rst 2 cycles later -> next cycle shows IDLE reset values. No res_valid ever appears for that operation.
- Random sweep: 200 random a, b, cin values with random res_ready gaps. Check {cout, sum} == a + b + cin for each, and that the issue interval is never below 6 cycles.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and limits for the bit-serial adder sequencer.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int unsigned MAX_WIDTH = 32;

endpackage

// File: rtl/serial_add_ctrl_fa_bit.sv
// Combinational 1-bit full adder; the only arithmetic cell of the serial adder.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, carry flop closes the loop.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] sum_sh_q;
  logic [WIDTH-1:0] sum_sh_d;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic [CNT_W-1:0] cnt_q;
  logic             s_bit;
  logic             co_bit;

  fa_bit u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (s_bit),
    .cout (co_bit)
  );

  assign sum_sh_d = {s_bit, sum_sh_q[WIDTH-1:1]};

  // sum_q/cout_q are a separate result holding register so the outputs keep the
  // last completed result while the working shift register is reused.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            a_sh_q   <= a;
            b_sh_q   <= b;
            carry_q  <= cin;
            sum_sh_q <= '0;
            cnt_q    <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          sum_sh_q <= sum_sh_d;
          carry_q  <= co_bit;
          if (cnt_q == CNT_LAST) begin
            sum_q   <= sum_sh_d;
            cout_q  <= co_bit;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign busy        = (state_q == RUN) || (state_q == DONE);
  assign sum         = sum_q;
  assign cout        = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed plus random checks of serial_add_ctrl against plain integer addition.
module tb_serial_add_ctrl;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int cyc      = 0;
  int n_assert = 0;
  int n_fail   = 0;
  int last_acc = -100;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; optionally offers the next operands while the result is held.
  task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                         input int gap, input bit offer,
                         input logic [W-1:0] na, input logic [W-1:0] nb, input logic nc);
    int acc;
    int expv;
    logic [W-1:0] es;
    logic ec;
    expv = int'(ta) + int'(tb_) + int'(tc);
    es   = W'(expv % (1 << W));
    ec   = ((expv >> W) & 1) != 0;
    a = ta; b = tb_; cin = tc; start_valid = 1'b1;
    for (int i = 0; i < 30 && !start_ready; i++) step();
    chk("start_ready_wait", start_ready, 1);
    acc = cyc;
    chk("issue_interval_ge6", (acc - last_acc) >= 6, 1);
    last_acc = acc;
    step();
    start_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    chk("busy_after_accept", {busy, start_ready, res_valid}, 3'b100);
    for (int i = 0; i < 30 && !res_valid; i++) step();
    chk("res_valid_wait", res_valid, 1);
    chk("latency", cyc - acc, W + 1);
    chk("result", {cout, sum}, {ec, es});
    if (offer) begin
      a = na; b = nb; cin = nc; start_valid = 1'b1;
    end
    for (int i = 0; i < gap; i++) begin
      step();
      chk("hold", {res_valid, start_ready, busy, cout, sum}, {1'b1, 1'b0, 1'b1, ec, es});
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("idle_after_handshake", {busy, res_valid, start_ready}, 3'b001);
    chk("result_kept_in_idle", {cout, sum}, {ec, es});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit           seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    int           gap;

    rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("reset_outputs", {start_ready, res_valid, busy, cout, sum}, 8'h80);

    run_add(4'd1, 4'd1, 1'b1, 0, 1'b0, '0, '0, 1'b0);
    run_add(4'd4, 4'd2, 1'b0, 1, 1'b0, '0, '0, 1'b0);
    run_add(4'd3, 4'd3, 1'b1, 0, 1'b0, '0, '0, 1'b0);
    run_add(4'd15, 4'd1, 1'b0, 2, 1'b0, '0, '0, 1'b0);
    run_add(4'd15, 4'd15, 1'b1, 0, 1'b0, '0, '0, 1'b0);

    // Backpressure with a pending offer; the pending add must start only after the handshake.
    run_add(4'd4, 4'd4, 1'b0, 6, 1'b1, 4'd9, 4'd5, 1'b1);
    run_add(4'd9, 4'd5, 1'b1, 0, 1'b0, '0, '0, 1'b0);

    a = 4'd2; b = 4'd4; cin = 1'b1; start_valid = 1'b1;
    for (int i = 0; i < 30 && !start_ready; i++) step();
    last_acc = cyc;
    step();
    start_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("reset_mid_run", {start_ready, res_valid, busy, cout, sum}, 8'h80);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (res_valid) seen = 1'b1;
    end
    chk("no_result_after_abort", seen, 0);

    for (int n = 0; n < 200; n++) begin
      ra  = W'($urandom_range(0, (1 << W) - 1));
      rb  = W'($urandom_range(0, (1 << W) - 1));
      rc  = 1'($urandom_range(0, 1));
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
      run_add(ra, rb, rc, gap, 1'b0, '0, '0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
